timer_entry_buffer: RTL and testbench
=====================================

// Module: timer_entry_buffer
// PURPOSE
//   Keypad-to-timer front end for the microwave countdown chain. Collects BCD key
//   digits into a 4-digit MM:SS buffer with microwave-style shift-left entry and
//   validates the seconds-tens digit. On START it issues a one-cycle load plus the
//   four digits to the downstream BCD down-counter digits (mod-10/mod-6 chain).
//   It then releases stop and holds run control until the chain reports zero or
//   CANCEL is pressed.
// PARAMETERS
//   MAX_SEC_TENS  5      largest legal seconds-tens digit; START is rejected above it
//   START_CODE    4'hA   key_code value meaning START
//   CANCEL_CODE   4'hB   key_code value meaning CANCEL
// PORTS
//   clk          in   1  system clock, all logic on posedge
//   reset        in   1  synchronous, active-high reset
//   key_valid    in   1  one-cycle strobe; key_code is valid while high
//   key_code     in   4  0..9 digit, START_CODE, CANCEL_CODE; other values ignored
//   timer_zero   in   1  high when all downstream counter digits read 0
//   min_tens     out  4  buffered BCD digit to counter chain (MM:SS, M tens)
//   min_units    out  4  buffered BCD digit, minutes units
//   sec_tens     out  4  buffered BCD digit, seconds tens
//   sec_units    out  4  buffered BCD digit, seconds units
//   load_o       out  1  active-high, one-cycle load to every counter digit
//   clear_o      out  1  active-high, one-cycle clear to every counter digit
//   stop_o       out  1  high = counters hold; low = counting
//   digit_count  out  3  digits entered so far, 0..4
//   err          out  1  one-cycle pulse on rejected START
//   done         out  1  one-cycle pulse when a run ends on timer_zero
// BEHAVIOUR
//   Reset: state=IDLE; all digits 0; digit_count=0; stop_o=1; load_o, clear_o, err, done = 0.
//     Reset overrides every other input in the same cycle, including mid-run.
//   All outputs are registered. Key effects appear on the cycle after the key_valid edge.
//   FSM states: IDLE, ENTRY, LOAD, RUN.
//   IDLE, digit key: shift the key in and go to ENTRY with digit_count=1.
//     START and CANCEL are no-ops in IDLE.
//   ENTRY, digit key with digit_count<4: shift left and increment digit_count.
//     Shift order: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key.
//     With digit_count==4, digit keys are ignored and the buffer is unchanged.
//   ENTRY, START: if sec_tens>MAX_SEC_TENS or all four digits are 0, pulse err and stay
//     in ENTRY with the buffer unchanged. Otherwise go to LOAD.
//   ENTRY, CANCEL: zero the buffer and digit_count, go to IDLE.
//   LOAD (exactly one cycle): load_o=1 and stop_o=1. The digits are stable this cycle.
//     Always continues to RUN. Keys arriving in LOAD are ignored.
//   RUN: stop_o=0. Digit and START keys are ignored.
//     timer_zero=1: stop_o=1, pulse done, zero the buffer, go to IDLE.
//     CANCEL: stop_o=1, pulse clear_o, zero the buffer, go to IDLE.
//     CANCEL and timer_zero in the same cycle: the CANCEL path wins (clear_o=1, done=0).
//   Latency: START strobe, then load_o on the next cycle, then stop_o falls one cycle later.
//   load_o and clear_o are never high together. err, done, clear_o are 1-cycle pulses.
//   Unknown key codes (0xC..0xF) have no effect in any state.
// TESTING
//   T1 reset mid-RUN -> next cycle state IDLE, stop_o=1, digits 0000, load_o=0.
//   T2 keys 1,3,0,START -> digits 01:30, load_o high exactly 1 cycle, then stop_o=0.
//   T3 keys 1,2,3,4,5 -> digits 12:34 (5th digit ignored), digit_count=4.
//   T4 keys 1,7,5,START -> err pulse, buffer 01:75 kept, state ENTRY, no load_o.
//   T5 keys 0,0,START -> err pulse, no load_o; START in IDLE -> no effect.
//   T6 RUN, CANCEL and timer_zero same cycle -> clear_o=1, done=0, stop_o=1, IDLE.

Source files
------------

// File: rtl/timer_entry_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_buffer_if
//  Description : Keypad / counter-chain signal bundle for timer_entry_buffer.
//                The slave modport is the buffer's own view of the bundle.
//                The master modport is the keypad and counter-chain view.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_entry_buffer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_zero;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       load_o;
    logic       clear_o;
    logic       stop_o;
    logic [2:0] digit_count;
    logic       err;
    logic       done;

    modport master (
        output key_valid, key_code, timer_zero,
        input  min_tens, min_units, sec_tens, sec_units,
        input  load_o, clear_o, stop_o, digit_count, err, done
    );

    modport slave (
        input  key_valid, key_code, timer_zero,
        output min_tens, min_units, sec_tens, sec_units,
        output load_o, clear_o, stop_o, digit_count, err, done
    );
endinterface
`default_nettype wire

// File: rtl/timer_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_buffer
//  Description : Collects BCD keypad digits into an MM:SS buffer using
//                microwave-style shift-left entry. START validates the
//                entry and loads the downstream BCD down-counter chain. The
//                block then runs the chain until it reads zero or CANCEL is
//                pressed.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_entry_buffer #(
    parameter logic [3:0] MAX_SEC_TENS = 4'd5,
    parameter logic [3:0] START_CODE   = 4'hA,
    parameter logic [3:0] CANCEL_CODE  = 4'hB
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_entry_buffer_if.slave  tmr_if
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] min_tens_q;
    logic [3:0] min_units_q;
    logic [3:0] sec_tens_q;
    logic [3:0] sec_units_q;
    logic [2:0] digit_count_q;
    logic       load_q;
    logic       clear_q;
    logic       stop_q;
    logic       err_q;
    logic       done_q;

    // Key decode. START and CANCEL are checked before the digit range, so a
    // command code placed inside 0..9 would still act as a command.
    logic w_key_start;
    logic w_key_cancel;
    logic w_key_digit;
    logic w_entry_bad;

    assign w_key_start  = tmr_if.key_valid && (tmr_if.key_code == START_CODE);
    assign w_key_cancel = tmr_if.key_valid && (tmr_if.key_code == CANCEL_CODE);
    assign w_key_digit  = tmr_if.key_valid && !w_key_start && !w_key_cancel
                          && (tmr_if.key_code <= 4'd9);

    // An all-zero time or a seconds-tens digit above the limit cannot be run.
    assign w_entry_bad  = (sec_tens_q > MAX_SEC_TENS) ||
                          ({min_tens_q, min_units_q, sec_tens_q, sec_units_q} == 16'h0000);

    // Entry/run state machine. It registers every output, and the pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            min_tens_q    <= 4'd0;
            min_units_q   <= 4'd0;
            sec_tens_q    <= 4'd0;
            sec_units_q   <= 4'd0;
            digit_count_q <= 3'd0;
            load_q        <= 1'b0;
            clear_q       <= 1'b0;
            stop_q        <= 1'b1;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The buffer is already zero in IDLE, so a plain shift-in leaves 000d.
                    if (w_key_digit) begin
                        min_tens_q    <= min_units_q;
                        min_units_q   <= sec_tens_q;
                        sec_tens_q    <= sec_units_q;
                        sec_units_q   <= tmr_if.key_code;
                        digit_count_q <= 3'd1;
                        state_q       <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_key_start) begin
                        if (w_entry_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            load_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end else if (w_key_cancel) begin
                        min_tens_q    <= 4'd0;
                        min_units_q   <= 4'd0;
                        sec_tens_q    <= 4'd0;
                        sec_units_q   <= 4'd0;
                        digit_count_q <= 3'd0;
                        state_q       <= S_IDLE;
                    end else if (w_key_digit && (digit_count_q < 3'd4)) begin
                        min_tens_q    <= min_units_q;
                        min_units_q   <= sec_tens_q;
                        sec_tens_q    <= sec_units_q;
                        sec_units_q   <= tmr_if.key_code;
                        digit_count_q <= digit_count_q + 3'd1;
                    end
                end
                S_LOAD: begin
                    // load_o is high this cycle. Counting starts on the next one.
                    stop_q  <= 1'b0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // CANCEL wins over timer_zero, so a cancelled run never reports done.
                    if (w_key_cancel || tmr_if.timer_zero) begin
                        stop_q        <= 1'b1;
                        clear_q       <= w_key_cancel;
                        done_q        <= !w_key_cancel;
                        min_tens_q    <= 4'd0;
                        min_units_q   <= 4'd0;
                        sec_tens_q    <= 4'd0;
                        sec_units_q   <= 4'd0;
                        digit_count_q <= 3'd0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tmr_if.min_tens    = min_tens_q;
    assign tmr_if.min_units   = min_units_q;
    assign tmr_if.sec_tens    = sec_tens_q;
    assign tmr_if.sec_units   = sec_units_q;
    assign tmr_if.digit_count = digit_count_q;
    assign tmr_if.load_o      = load_q;
    assign tmr_if.clear_o     = clear_q;
    assign tmr_if.stop_o      = stop_q;
    assign tmr_if.err         = err_q;
    assign tmr_if.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_entry_buffer
//  Description : Self-checking bench for timer_entry_buffer. It applies
//                vectors from a table, then runs hand-written corner
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_entry_buffer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    timer_entry_buffer_if tmr_if ();

    timer_entry_buffer #(
        .MAX_SEC_TENS (4'd5),
        .START_CODE   (4'hA),
        .CANCEL_CODE  (4'hB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tmr_if (tmr_if)
    );

    // One clock step: the inputs to drive and the outputs expected after the edge.
    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  kc;
        logic        tz;
        logic [15:0] dig;
        logic [2:0]  cnt;
        logic        ld;
        logic        clr;
        logic        stp;
        logic        er;
        logic        dn;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] kc,
                                input logic tz, input logic [15:0] dig, input logic [2:0] cnt,
                                input logic ld, input logic clr, input logic stp,
                                input logic er, input logic dn);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kc = kc; v.tz = tz;
        v.dig = dig; v.cnt = cnt; v.ld = ld; v.clr = clr;
        v.stp = stp; v.er = er; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, nm, act, exp);
        end
    endtask

    // Drive one step, queue its expectation, then compare the DUT against the popped entry.
    task automatic step(input vec_t v);
        vec_t e;
        reset            = v.rst;
        tmr_if.key_valid = v.kv;
        tmr_if.key_code  = v.kc;
        tmr_if.timer_zero = v.tz;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("digits", {tmr_if.min_tens, tmr_if.min_units, tmr_if.sec_tens, tmr_if.sec_units}, e.dig);
        chk("digit_count", {13'd0, tmr_if.digit_count}, {13'd0, e.cnt});
        chk("load_o",  {15'd0, tmr_if.load_o},  {15'd0, e.ld});
        chk("clear_o", {15'd0, tmr_if.clear_o}, {15'd0, e.clr});
        chk("stop_o",  {15'd0, tmr_if.stop_o},  {15'd0, e.stp});
        chk("err",     {15'd0, tmr_if.err},     {15'd0, e.er});
        chk("done",    {15'd0, tmr_if.done},    {15'd0, e.dn});
        step_no++;
    endtask

    initial begin
        reset             = 1'b1;
        tmr_if.key_valid  = 1'b0;
        tmr_if.key_code   = 4'h0;
        tmr_if.timer_zero = 1'b0;

        //                 rst kv kc    tz dig       cnt ld clr stp er dn
        // Reset state
        tbl.push_back(mk(1, 0, 4'h0, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // T3: five digits, the fifth one is ignored
        tbl.push_back(mk(0, 1, 4'h1, 0, 16'h0001, 3'd1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h2, 0, 16'h0012, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 0, 16'h0123, 3'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h4, 0, 16'h1234, 3'd4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 16'h1234, 3'd4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 16'h1234, 3'd4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hB, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // T5: START in IDLE does nothing; an all-zero entry is rejected
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 0, 16'h0000, 3'd1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 0, 16'h0000, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0000, 3'd2, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 16'h0000, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hB, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hC, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // T4: seconds-tens 7 is rejected, the buffer is kept, and unknown codes are ignored
        tbl.push_back(mk(0, 1, 4'h1, 0, 16'h0001, 3'd1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h7, 0, 16'h0017, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 16'h0175, 3'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0175, 3'd3, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 4'hE, 0, 16'h0175, 3'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hB, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // T2: 01:30 loads for one cycle, keys are ignored in LOAD/RUN, then timer_zero ends the run
        tbl.push_back(mk(0, 1, 4'h1, 0, 16'h0001, 3'd1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 0, 16'h0013, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 0, 16'h0130, 3'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0130, 3'd3, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h9, 0, 16'h0130, 3'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 16'h0130, 3'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0130, 3'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 16'h0000, 3'd0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // Boundary: seconds-tens equal to the limit (00:59) is accepted
        tbl.push_back(mk(0, 1, 4'h5, 0, 16'h0005, 3'd1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h9, 0, 16'h0059, 3'd2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 16'h0059, 3'd2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 16'h0059, 3'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 16'h0059, 3'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 16'h0000, 3'd0, 0, 0, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // T6: CANCEL and timer_zero arrive together in RUN, and CANCEL wins
        step(mk(0, 1, 4'h2, 0, 16'h0002, 3'd1, 0, 0, 1, 0, 0));
        step(mk(0, 1, 4'h5, 0, 16'h0025, 3'd2, 0, 0, 1, 0, 0));
        step(mk(0, 1, 4'hA, 0, 16'h0025, 3'd2, 1, 0, 1, 0, 0));
        step(mk(0, 0, 4'h0, 0, 16'h0025, 3'd2, 0, 0, 0, 0, 0));
        step(mk(0, 1, 4'hB, 1, 16'h0000, 3'd0, 0, 1, 1, 0, 0));
        step(mk(0, 0, 4'h0, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        // A digit after the cancelled run starts a fresh entry
        step(mk(0, 1, 4'h8, 0, 16'h0008, 3'd1, 0, 0, 1, 0, 0));
        step(mk(0, 1, 4'hB, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));

        // T1: reset mid-RUN overrides a simultaneous key and timer_zero
        step(mk(0, 1, 4'h9, 0, 16'h0009, 3'd1, 0, 0, 1, 0, 0));
        step(mk(0, 1, 4'hA, 0, 16'h0009, 3'd1, 1, 0, 1, 0, 0));
        step(mk(0, 0, 4'h0, 0, 16'h0009, 3'd1, 0, 0, 0, 0, 0));
        step(mk(1, 1, 4'hB, 1, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        step(mk(0, 1, 4'h4, 0, 16'h0004, 3'd1, 0, 0, 1, 0, 0));

        // Reset during LOAD also drops load_o immediately
        step(mk(0, 1, 4'hA, 0, 16'h0004, 3'd1, 1, 0, 1, 0, 0));
        step(mk(1, 0, 4'h0, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));
        step(mk(0, 0, 4'h0, 0, 16'h0000, 3'd0, 0, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
